fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end: owns the fetch PC, issues in-order word requests to the
//  instruction bus with a valid/ready handshake, and buffers returning words with their PCs
//  in a DEPTH-entry queue feeding decode. Supports several outstanding requests, in-order
//  responses, and redirects (branch/exception) that discard in-flight and buffered work.
// PARAMETERS
//  RESET_PC  32'hbfc0_0000  first fetch address after reset
//  DEPTH     4              queue entries (power of 2, >=2); also caps in-flight requests
//  ADDR_W    32             PC / bus address width
//  DATA_W    32             instruction word width
// PORTS
//  clk            in   1       clock, all state on rising edge
//  resetn         in   1       asynchronous, active-low reset
//  redirect_valid in   1       replace fetch stream this cycle
//  redirect_pc    in   ADDR_W  new fetch PC
//  ireq_valid     out  1       bus request valid
//  ireq_addr      out  ADDR_W  bus request address
//  ireq_ready     in   1       bus accepts request this cycle
//  iresp_valid    in   1       in-order response word valid (no backpressure)
//  iresp_data     in   DATA_W  response word
//  out_valid      out  1       queue head holds a returned instruction
//  out_pc         out  ADDR_W  PC of head
//  out_instr      out  DATA_W  instruction of head
//  out_ready      in   1       decode consumes head
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, drop_cnt=0, ireq_valid=0, out_valid=0; all
//   pointers/counters 0. Reset mid-operation abandons everything; bus is reset with us.
//  Entry: {pc, instr, filled}. Allocated (pc stored, filled=0) at request acceptance;
//   filled by response (oldest unfilled entry, pointer fill_ptr); freed at out handshake.
//  Credit: new request may be raised when count + drop_cnt < DEPTH (count = allocated).
//  Issue: ireq_addr = fetch_pc. Accept = ireq_valid & ireq_ready -> allocate entry,
//   fetch_pc += 4 (mod 2^ADDR_W, wraps). Once raised, ireq_valid/ireq_addr stay stable
//   until accepted, even across a redirect.
//  Response: if drop_cnt>0 -> word discarded, drop_cnt-=1; else write oldest unfilled.
//   Response with no outstanding request is a bus protocol violation (assertion).
//  Output: out_valid = head allocated & filled; head pops on out_valid & out_ready.
//   Latency: request accept at cycle N, response at N+k -> out_valid at N+k+1.
//  Redirect (priority over sequential update):
//   - out handshake in same cycle still pops (instruction delivered); all other entries freed.
//   - drop_cnt += allocated-unfilled entries (incl. one filled by a same-cycle response,
//     which is instead counted as dropped) + 1 if a request is accepted this cycle.
//   - Pending unaccepted request: remains on bus; when accepted it is not allocated and
//     drop_cnt += 1; fetch_pc then = redirect_pc (not redirect_pc+4).
//   - No pending request: fetch_pc = redirect_pc; first new request earliest next cycle.
//   - Back-to-back redirects: last one wins; drop_cnt accumulates, bounded by DEPTH.
//  Full: count+drop_cnt==DEPTH -> ireq_valid stays low (unless already pending).
//  Empty: out_valid=0; out_pc/out_instr don't-care.
//  Widths: count, drop_cnt are $clog2(DEPTH+1) bits; pointers $clog2(DEPTH), wrap naturally.
//  redirect_pc low bits passed through unchecked; alignment faults are raised downstream.
// TESTING
//  1 Reset, ireq_ready=1, 1-cycle responses, out_ready=1 -> addrs bfc00000,04,08..;
//    out_pc matches with instr in order, one per cycle steady state.
//  2 out_ready=0, ireq_ready=1, DEPTH=4 -> exactly 4 requests accepted, ireq_valid then 0;
//    release out_ready -> 4 ordered outputs, fetching resumes at bfc00010.
//  3 Three outstanding (bfc00000..08, none returned), redirect to 80000180 -> drop_cnt=3;
//    next 3 responses never appear on out; next out_pc=80000180.
//  4 ireq_valid high, ireq_ready=0, redirect to 80001000 -> ireq_addr unchanged until
//    accepted; its response dropped; next ireq_addr=80001000.
//  5 Redirect same cycle as out handshake and as a response -> popped head delivered once,
//    response dropped, queue empty next cycle.
//  6 Assert resetn low with 2 outstanding and 1 buffered -> outputs at reset values
//    immediately; after release first ireq_addr=RESET_PC; fetch_pc wrap ffffffFC -> 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end. Owns the fetch PC, issues in-order word requests on the
// instruction bus (valid/ready) and buffers returning words with their PCs in a DEPTH-entry
// queue that feeds decode. Redirects discard in-flight and buffered work.
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   redirect_valid, redirect_pc  replace the fetch stream with one starting at redirect_pc
//   ireq_valid/addr/ready        bus request handshake
//   iresp_valid/data             in-order response word (no backpressure)
//   out_valid/pc/instr/ready     queue head towards decode
module fetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ireq_valid,
  output logic [ADDR_W-1:0] ireq_addr,
  input  logic              ireq_ready,
  input  logic              iresp_valid,
  input  logic [DATA_W-1:0] iresp_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  // pc_q is the address of the request on (or next onto) the bus. When a redirect hits a
  // raised-but-unaccepted request, that request is held (stale_q) and the new stream start
  // waits in tgt_q until it is accepted.
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic              stale_q, stale_d;
  logic              run_q;
  logic [CntW-1:0]   count_q, count_d;  // allocated entries
  logic [CntW-1:0]   unf_q, unf_d;      // allocated but not yet filled
  logic [CntW-1:0]   drop_q, drop_d;    // responses still owed to discarded requests
  logic [PtrW-1:0]   wr_q, wr_d, fill_q, fill_d, rd_q, rd_d;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DEPTH-1:0]  filled_q;

  logic [CntW:0] credit_sum, drop_sum;
  logic          acc, alloc, resp_drop, do_fill, pop;

  assign credit_sum = {1'b0, count_q} + {1'b0, drop_q};
  // run_q keeps the bus quiet while reset is asserted and for the first cycle after it.
  assign ireq_valid = run_q & (credit_sum < (CntW + 1)'(DEPTH));
  assign ireq_addr  = pc_q;
  assign acc        = ireq_valid & ireq_ready;
  assign alloc      = acc & ~stale_q & ~redirect_valid;
  assign resp_drop  = iresp_valid & (drop_q != '0);
  assign do_fill    = iresp_valid & (drop_q == '0) & ~redirect_valid;

  assign out_valid  = (count_q != '0) & filled_q[rd_q];
  assign out_pc     = pc_mem[rd_q];
  assign out_instr  = instr_mem[rd_q];
  assign pop        = out_valid & out_ready;

  // On redirect every response still owed (dropped or unfilled, plus one accepted now) is
  // to be discarded; a response arriving in the same cycle pays one of them off.
  assign drop_sum = {1'b0, drop_q} + {1'b0, unf_q} + (CntW + 1)'(acc)
                  - (CntW + 1)'(iresp_valid);

  always_comb begin
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    stale_d = stale_q;
    count_d = count_q;
    unf_d   = unf_q;
    drop_d  = drop_q;
    wr_d    = wr_q;
    fill_d  = fill_q;
    rd_d    = rd_q;
    if (redirect_valid) begin
      count_d = '0;
      unf_d   = '0;
      wr_d    = '0;
      fill_d  = '0;
      rd_d    = '0;
      drop_d  = drop_sum[CntW-1:0];
      if (acc) begin
        pc_d    = redirect_pc;
        stale_d = 1'b0;
      end else if (ireq_valid) begin
        stale_d = 1'b1;
        tgt_d   = redirect_pc;
      end else begin
        pc_d    = redirect_pc;
      end
    end else begin
      count_d = count_q + CntW'(alloc) - CntW'(pop);
      unf_d   = unf_q + CntW'(alloc) - CntW'(do_fill);
      drop_d  = drop_q - CntW'(resp_drop) + CntW'(acc & stale_q);
      wr_d    = wr_q + PtrW'(alloc);
      fill_d  = fill_q + PtrW'(do_fill);
      rd_d    = rd_q + PtrW'(pop);
      if (acc) begin
        if (stale_q) begin
          pc_d    = tgt_q;
          stale_d = 1'b0;
        end else begin
          pc_d    = pc_q + ADDR_W'(4);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      stale_q  <= 1'b0;
      run_q    <= 1'b0;
      count_q  <= '0;
      unf_q    <= '0;
      drop_q   <= '0;
      wr_q     <= '0;
      fill_q   <= '0;
      rd_q     <= '0;
      filled_q <= '0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      stale_q <= stale_d;
      run_q   <= 1'b1;
      count_q <= count_d;
      unf_q   <= unf_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
      if (alloc) filled_q[wr_q] <= 1'b0;
      if (do_fill) filled_q[fill_q] <= 1'b1;
    end
  end

  // Payload storage needs no reset: out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (alloc) pc_mem[wr_q] <= pc_q;
    if (do_fill) instr_mem[fill_q] <= iresp_data;
  end

`ifndef SYNTHESIS
  // A response must always have an outstanding request behind it.
  resp_has_req_a: assert property (@(posedge clk) disable iff (!resetn)
    iresp_valid |-> ((drop_q != '0) || (unf_q != '0)));
`endif

endmodule
